inventory_scheduler: RTL

//  Sequences one Gen2 inventory round over the reader TX/RX datapath.

---
 rtl/inventory_scheduler_pkg.sv | 34 +++
 rtl/inventory_scheduler_if.sv | 25 ++
 rtl/inventory_scheduler_timer.sv | 22 ++
 rtl/inventory_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/inventory_scheduler_pkg.sv
// Shared types for the Gen2 inventory scheduler: command codes, FSM states, reply phase.
// No logic, no latency; types only.
package rfid_pkg;

  typedef enum logic [1:0] {
    CMD_NONE     = 2'd0,
    CMD_QUERY    = 2'd1,
    CMD_QUERYREP = 2'd2,
    CMD_ACK      = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_TX,
    ST_T1,
    ST_RX,
    ST_T2,
    ST_DONE
  } state_t;

  typedef enum logic {
    PH_RN16,
    PH_EPC
  } phase_t;

  localparam int TIMER_W = 16;

  // Index of the final slot for exponent q; 16-bit so q=15 yields 32767 with no wrap.
  function automatic logic [15:0] last_slot(input logic [3:0] q);
    return (16'd1 << q) - 16'd1;
  endfunction

endpackage

// File: rtl/inventory_scheduler_if.sv
// Command handshake and RX-chain control between the scheduler (master) and ctrl_fsm/RX (slave).
// Pure wiring; cmd_vld/cmd_rdy is a valid-ready handshake, the rest are pulses/levels.
interface inventory_scheduler_if;
  import rfid_pkg::*;

  logic cmd_vld;
  cmd_t cmd_type;
  logic cmd_rdy;
  logic tx_done;
  logic preamble_detected;
  logic frame_done;
  logic crc_ok;
  logic rx_en;
  logic rx_rst;

  modport master (
    output cmd_vld, cmd_type, rx_en, rx_rst,
    input  cmd_rdy, tx_done, preamble_detected, frame_done, crc_ok
  );

  modport slave (
    input  cmd_vld, cmd_type, rx_en, rx_rst,
    output cmd_rdy, tx_done, preamble_detected, frame_done, crc_ok
  );
endinterface

// File: rtl/inventory_scheduler_timer.sv
// sched_timer: clearable up-counter shared by the T1/RX/T2 windows; hit flags cnt==limit while enabled.
// hit is combinational from the registered count; no backpressure.
module sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         hit
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign hit = en && (cnt == limit);

endmodule

// File: rtl/inventory_scheduler.sv
// Sequences one Gen2 inventory round (QUERY/QUERYREP/ACK) with T1/RX/T2 windows and tag/collision counts.
// Commands wait indefinitely on cmd_rdy; build with ACK_RETRY_EN to re-send ACK once per slot after an EPC failure.
module inventory_scheduler
  import rfid_pkg::*;
#(
  parameter int T1_MAX_CYCLES = 400,
  parameter int RX_MAX_CYCLES = 4000,
  parameter int T2_CYCLES     = 100,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [3:0]            q_init,
  inventory_scheduler_if.master bus,
  output logic                  busy,
  output logic                  round_done,
  output logic [15:0]           slot_idx,
  output logic [CNT_W-1:0]      tag_count,
  output logic [CNT_W-1:0]      coll_count
);

  localparam logic [TIMER_W-1:0] T1_LIM = TIMER_W'(T1_MAX_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RX_LIM = TIMER_W'(RX_MAX_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T2_LIM = TIMER_W'(T2_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_nxt;
  phase_t phase;
  cmd_t   cmd_q;
  logic [3:0] q_lat;
  logic t2_ack;

  logic ld_start, ld_ack, ld_next, inc_tag, inc_coll, go_ack, go_next, epc_fail;
`ifdef ACK_RETRY_EN
  logic retry_used, set_retry;
`endif

  logic [TIMER_W-1:0] tmr_cnt, tmr_limit;
  logic tmr_hit, tmr_en, tmr_clr;

  always_comb begin
    unique case (state)
      ST_T1:   tmr_limit = T1_LIM;
      ST_RX:   tmr_limit = RX_LIM;
      default: tmr_limit = T2_LIM;
    endcase
  end

  assign tmr_en  = (state == ST_T1) || (state == ST_RX) || (state == ST_T2);
  assign tmr_clr = (state_nxt != state);

  sched_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .cnt   (tmr_cnt),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    ld_ack    = 1'b0;
    ld_next   = 1'b0;
    inc_tag   = 1'b0;
    inc_coll  = 1'b0;
    go_ack    = 1'b0;
    go_next   = 1'b0;
    epc_fail  = 1'b0;
`ifdef ACK_RETRY_EN
    set_retry = 1'b0;
`endif
    if (stop) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin state_nxt = ST_CMD; ld_start = 1'b1; end
        ST_CMD:  if (bus.cmd_rdy) state_nxt = ST_TX;
        ST_TX:   if (bus.tx_done) state_nxt = ST_T1;
        ST_T1: begin
          if (bus.preamble_detected) state_nxt = ST_RX;
          else if (tmr_hit) begin state_nxt = ST_T2; go_next = 1'b1; end
        end
        ST_RX: begin
          if (bus.frame_done) begin
            state_nxt = ST_T2;
            if (phase == PH_RN16) begin go_ack = 1'b1; ld_ack = 1'b1; end
            else if (bus.crc_ok) begin inc_tag = 1'b1; go_next = 1'b1; end
            else epc_fail = 1'b1;
          end else if (tmr_hit) begin
            state_nxt = ST_T2;
            if (phase == PH_EPC) epc_fail = 1'b1;
            else begin inc_coll = 1'b1; go_next = 1'b1; end
          end
        end
        ST_T2: begin
          if (tmr_hit) begin
            if (t2_ack) state_nxt = ST_CMD;
            else if (slot_idx == last_slot(q_lat)) state_nxt = ST_DONE;
            else begin state_nxt = ST_CMD; ld_next = 1'b1; end
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
      // A failed EPC either earns one ACK retry for this slot or is counted as a collision.
      if (epc_fail) begin
`ifdef ACK_RETRY_EN
        if (!retry_used) begin go_ack = 1'b1; ld_ack = 1'b1; set_retry = 1'b1; end
        else begin inc_coll = 1'b1; go_next = 1'b1; end
`else
        inc_coll = 1'b1;
        go_next  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_RN16;
      cmd_q      <= CMD_NONE;
      q_lat      <= 4'd0;
      t2_ack     <= 1'b0;
      slot_idx   <= 16'd0;
      tag_count  <= '0;
      coll_count <= '0;
`ifdef ACK_RETRY_EN
      retry_used <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (ld_start) begin
        q_lat      <= q_init;
        slot_idx   <= 16'd0;
        tag_count  <= '0;
        coll_count <= '0;
        phase      <= PH_RN16;
        cmd_q      <= CMD_QUERY;
      end
      if (ld_ack) begin
        phase <= PH_EPC;
        cmd_q <= CMD_ACK;
      end
      if (ld_next) begin
        slot_idx <= slot_idx + 16'd1;
        phase    <= PH_RN16;
        cmd_q    <= CMD_QUERYREP;
      end
      if (go_ack)  t2_ack <= 1'b1;
      if (go_next) t2_ack <= 1'b0;
      if (inc_tag && (tag_count != '1))   tag_count  <= tag_count + CNT_ONE;
      if (inc_coll && (coll_count != '1)) coll_count <= coll_count + CNT_ONE;
`ifdef ACK_RETRY_EN
      if (ld_start || ld_next) retry_used <= 1'b0;
      else if (set_retry)      retry_used <= 1'b1;
`endif
    end
  end

  assign bus.cmd_vld  = (state == ST_CMD);
  assign bus.cmd_type = (state == ST_CMD) ? cmd_q : CMD_NONE;
  assign bus.rx_en    = (state == ST_T1) || (state == ST_RX);
  assign bus.rx_rst   = rst || ((state == ST_TX) && bus.tx_done && !stop);
  assign busy         = (state != ST_IDLE);
  assign round_done   = (state == ST_DONE);

endmodule
